// File: rtl/input_debouncer_pkg.sv
// Shared constants for the four-input debouncer and the gate bench.
// Bit order of the raw bus is {A,B,C,D}, MSB first.
package input_debouncer_pkg;

    localparam int NUM_INPUTS            = 4;
    localparam int STABLE_CYCLES_DEFAULT = 4;

    localparam int IDX_A = 3;
    localparam int IDX_B = 2;
    localparam int IDX_C = 1;
    localparam int IDX_D = 0;

    typedef enum logic {
        FILT_STABLE   = 1'b0,
        FILT_COUNTING = 1'b1
    } filt_state_t;

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// One-bit synchronizer plus stability filter with a registered output level.
// Latency: out moves STABLE_CYCLES+2 edges after raw settles; upd is combinational.
// No backpressure: free-running, one accepted change per STABLE_CYCLES cycles.
module debounce_bit
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic out,
    output logic upd
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             out_nxt;
    filt_state_t      state;

    // Any return to the held level drops the count to zero, so partial runs never accumulate.
    always_comb begin
        state   = (sync2 == out) ? FILT_STABLE : FILT_COUNTING;
        cnt_nxt = '0;
        out_nxt = out;
        upd     = 1'b0;
        case (state)
            FILT_COUNTING: begin
                if (cnt == TERM_CNT) begin
                    out_nxt = sync2;
                    upd     = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cnt   <= cnt_nxt;
            out   <= out_nxt;
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Debounces four raw inputs into registered A..D plus a one-cycle CHANGED strobe.
// Latency: STABLE_CYCLES+2 edges from a stable RAW to A..D and CHANGED.
// No backpressure: outputs update unconditionally; CHANGED is never held.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_INPUTS-1:0] RAW,
    output logic                  A,
    output logic                  B,
    output logic                  C,
    output logic                  D,
    output logic                  CHANGED
);

    logic [NUM_INPUTS-1:0] deb;
    logic [NUM_INPUTS-1:0] upd;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_bit (
            .CLK(CLK),
            .RST(RST),
            .raw(RAW[i]),
            .out(deb[i]),
            .upd(upd[i])
        );
    end

    // Registered alongside the output flops so the strobe lands in the same cycle as the new level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CHANGED <= 1'b0;
        end else begin
            CHANGED <= |upd;
        end
    end

    assign A = deb[IDX_A];
    assign B = deb[IDX_B];
    assign C = deb[IDX_C];
    assign D = deb[IDX_D];

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed vector table, hand-written corner sequences,
// and randomized RAW checked every cycle against a sliding-window reference model.
module tb_input_debouncer;
    import input_debouncer_pkg::*;

    localparam int SC = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] RAW = 4'b0000;
    logic       A, B, C, D, CHANGED;
    logic [3:0] outs;

    assign outs = {A, B, C, D};

    input_debouncer #(.STABLE_CYCLES(SC)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .RAW    (RAW),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
        .CHANGED(CHANGED)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: a level is accepted when the last SC synchronized samples all disagree with it.
    bit [3:0] m_s1, m_s2, m_out;
    bit       m_chg;
    bit [3:0] hist [SC];

    task automatic model_edge();
        if (RST) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_chg = 1'b0;
            for (int j = 0; j < SC; j++) hist[j] = '0;
        end else begin
            for (int j = SC - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = m_s2;
            m_chg   = 1'b0;
            for (int i = 0; i < 4; i++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = 0; j < SC; j++)
                    if (hist[j][i] == m_out[i]) all_diff = 1'b0;
                if (all_diff) begin
                    m_out[i] = ~m_out[i];
                    m_chg    = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = RAW;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check("model", int'({outs, CHANGED}), int'({m_out, m_chg}));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        RAW = 4'b0000;
        tick();
        RST = 1'b0;
    endtask

    typedef struct {
        bit       rst;
        bit [3:0] raw;
        bit [3:0] exp_out;
        bit       exp_chg;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input bit [3:0] raw, input int n,
                       input bit [3:0] exp_out, input bit exp_chg);
        vec_t v;
        v.rst = rst; v.raw = raw; v.exp_out = exp_out; v.exp_chg = exp_chg;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    initial begin
        int       n;
        bit       d_seen;
        bit       found;
        int       pk[$];
        bit [3:0] po[$];
        bit [3:0] val;
        int       hold;

        // Reset/wake-up, fall back to zero, then a simultaneous 0000->1011 step.
        add(1, 4'hF, 2, 4'h0, 0);
        add(0, 4'hF, 5, 4'h0, 0);
        add(0, 4'hF, 1, 4'hF, 1);
        add(0, 4'hF, 1, 4'hF, 0);
        add(0, 4'h0, 5, 4'hF, 0);
        add(0, 4'h0, 1, 4'h0, 1);
        add(0, 4'h0, 1, 4'h0, 0);
        add(0, 4'hB, 5, 4'h0, 0);
        add(0, 4'hB, 1, 4'hB, 1);
        add(0, 4'hB, 1, 4'hB, 0);

        foreach (tbl[k]) begin
            RST = tbl[k].rst;
            RAW = tbl[k].raw;
            tick();
            check("table", int'({outs, CHANGED}), int'({tbl[k].exp_out, tbl[k].exp_chg}));
        end

        // Three-cycle glitch must be rejected outright.
        do_reset();
        n = 0; d_seen = 1'b0;
        for (int k = 0; k < 13; k++) begin
            RAW = (k < 3) ? 4'b0001 : 4'b0000;
            tick();
            if (CHANGED) n++;
            if (D) d_seen = 1'b1;
        end
        check("glitch3_pulses", n, 0);
        check("glitch3_d", int'(d_seen), 0);

        // Four-cycle pulse is exactly long enough: D rises then falls, two strobes.
        n = 0; d_seen = 1'b0;
        for (int k = 0; k < 14; k++) begin
            RAW = (k < 4) ? 4'b0001 : 4'b0000;
            tick();
            if (CHANGED) n++;
            if (D) d_seen = 1'b1;
        end
        check("pulse4_pulses", n, 2);
        check("pulse4_d_seen", int'(d_seen), 1);
        check("pulse4_d_final", int'(D), 0);

        // Staggered rises on A then C two cycles later.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            RAW = (k < 2) ? 4'b1000 : 4'b1010;
            tick();
            if (CHANGED) begin
                pk.push_back(k);
                po.push_back(outs);
            end
        end
        check("stagger_count", pk.size(), 2);
        if (pk.size() == 2) begin
            check("stagger_first_at", pk[0], 5);
            check("stagger_gap", pk[1] - pk[0], 2);
            check("stagger_out0", int'(po[0]), 'h8);
            check("stagger_out1", int'(po[1]), 'hA);
        end

        // Reset mid-count must discard the partial run.
        do_reset();
        RAW = 4'b0001;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        check("midrst_d", int'(D), 0);
        check("midrst_chg", int'(CHANGED), 0);
        RST = 1'b0;
        n = 0; found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (D) begin
                found = 1'b1;
                n = k + 1;
                check("midrst_chg_on_rise", int'(CHANGED), 1);
            end
        end
        check("midrst_edges", n, 6);

        // Random held segments of varying length, with the odd reset.
        do_reset();
        for (int s = 0; s < 600; s++) begin
            val  = 4'($urandom);
            hold = $urandom_range(1, 7);
            RST  = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < hold; k++) begin
                RAW = val;
                tick();
                RST = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
